// File: rtl/icache_pkg.sv
// Shared types and geometry helpers for the set-associative instruction cache.
// Tag storage is sized for the widest possible tag; narrower configurations zero-extend.
package icache_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MISS_REQ,
        S_REFILL,
        S_RESP
    } state_t;

    localparam int ADDR_W         = 30;
    localparam int MAX_TAG_W      = ADDR_W;
    localparam int DEF_SETS_LOG2  = 4;
    localparam int DEF_WORDS_LOG2 = 2;

    typedef struct packed {
        logic                 valid;
        logic [MAX_TAG_W-1:0] tag;
    } line_meta_t;

    function automatic int tag_width(input int sets_log2, input int words_log2);
        return ADDR_W - sets_log2 - words_log2;
    endfunction

    function automatic int unsigned num_lines(input int sets_log2);
        return 32'd1 << sets_log2;
    endfunction

    function automatic int unsigned num_words(input int words_log2);
        return 32'd1 << words_log2;
    endfunction

endpackage

// File: rtl/icache_way.sv
// One cache way: per-set valid/tag metadata plus the multi-word data array.
// Lookup is combinational; data beats and the final tag/valid update are written on the clock.
module icache_way
    import icache_pkg::*;
#(
    parameter  int SETS_LOG2  = DEF_SETS_LOG2,
    parameter  int WORDS_LOG2 = DEF_WORDS_LOG2,
    localparam int TAG_W      = tag_width(SETS_LOG2, WORDS_LOG2)
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_flush,
    input  logic [SETS_LOG2-1:0]  i_rd_set,
    input  logic [WORDS_LOG2-1:0] i_rd_word,
    input  logic [TAG_W-1:0]      i_rd_tag,
    output logic                  o_valid,
    output logic                  o_hit,
    output logic [31:0]           o_rdata,
    input  logic                  i_wr_en,
    input  logic [SETS_LOG2-1:0]  i_wr_set,
    input  logic [WORDS_LOG2-1:0] i_wr_word,
    input  logic [31:0]           i_wr_data,
    input  logic                  i_fill_done,
    input  logic [TAG_W-1:0]      i_fill_tag
);

    localparam int unsigned LINES = num_lines(SETS_LOG2);
    localparam int unsigned WORDS = num_words(WORDS_LOG2);

    line_meta_t  r_meta [LINES];
    logic [31:0] r_data [LINES*WORDS];
    line_meta_t  w_meta;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int unsigned i = 0; i < LINES; i++) r_meta[i] <= '0;
        end else if (i_flush) begin
            for (int unsigned i = 0; i < LINES; i++) r_meta[i].valid <= 1'b0;
        end else if (i_fill_done) begin
            r_meta[i_wr_set] <= '{valid: 1'b1, tag: MAX_TAG_W'(i_fill_tag)};
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_wr_en) r_data[{i_wr_set, i_wr_word}] <= i_wr_data;
    end

    assign w_meta  = r_meta[i_rd_set];
    assign o_valid = w_meta.valid;
    assign o_hit   = w_meta.valid && (w_meta.tag == MAX_TAG_W'(i_rd_tag));
    assign o_rdata = r_data[{i_rd_set, i_rd_word}];

endmodule

// File: rtl/icache_sa.sv
// Set-associative instruction cache: lookup, victim choice, refill FSM and hit/miss counters.
// Ways are instantiated per WAYS; round-robin pointers exist only when WAYS > 1.
module icache_sa
    import icache_pkg::*;
#(
    parameter  int WAYS       = 2,
    parameter  int SETS_LOG2  = DEF_SETS_LOG2,
    parameter  int WORDS_LOG2 = DEF_WORDS_LOG2,
    localparam int TAG_W      = tag_width(SETS_LOG2, WORDS_LOG2)
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        reqValid,
    input  logic [31:2] addr,
    output logic        reqReady,
    input  logic        flush,
    output logic        respValid,
    output logic [31:0] rdata,
    output logic        is_hit,
    output logic        memReqValid,
    input  logic        memReqReady,
    output logic [31:2] memAddr,
    input  logic        memRespValid,
    input  logic [31:0] memRdata,
    output logic [31:0] hitCount,
    output logic [31:0] missCount
);

    localparam int unsigned SETS = num_lines(SETS_LOG2);
    localparam int          VW   = (WAYS > 1) ? $clog2(WAYS) : 1;

    state_t                r_state, w_next;
    logic [TAG_W-1:0]      r_tag;
    logic [SETS_LOG2-1:0]  r_set;
    logic [WORDS_LOG2-1:0] r_word, r_beat;
    logic [VW-1:0]         r_victim;
    logic [31:0]           r_fill_word, r_rdata, r_hit_cnt, r_miss_cnt;
    logic                  r_resp_valid, r_is_hit;

    logic [TAG_W-1:0]      w_tag;
    logic [SETS_LOG2-1:0]  w_set;
    logic [WORDS_LOG2-1:0] w_word;
    logic [WAYS-1:0]       w_valid, w_hit;
    logic [31:0]           w_rdata [WAYS];
    logic [31:0]           w_hit_data;
    logic                  w_any_hit, w_found, w_flush, w_accept, w_beat, w_last, w_fill_done;
    logic [VW-1:0]         w_victim, w_rr_sel;

    assign w_tag  = addr[31 -: TAG_W];
    assign w_set  = addr[2+WORDS_LOG2 +: SETS_LOG2];
    assign w_word = addr[2 +: WORDS_LOG2];

    assign w_accept    = reqReady && reqValid;
    assign w_beat      = (r_state == S_REFILL) && memRespValid;
    assign w_last      = &r_beat;
    assign w_fill_done = w_beat && w_last;

    for (genvar g = 0; g < WAYS; g++) begin : g_way
        logic w_sel;
        assign w_sel = (r_victim == VW'(g));
        icache_way #(
            .SETS_LOG2  (SETS_LOG2),
            .WORDS_LOG2 (WORDS_LOG2)
        ) u_way (
            .i_clk       (clock),
            .i_rst       (reset),
            .i_flush     (w_flush),
            .i_rd_set    (w_set),
            .i_rd_word   (w_word),
            .i_rd_tag    (w_tag),
            .o_valid     (w_valid[g]),
            .o_hit       (w_hit[g]),
            .o_rdata     (w_rdata[g]),
            .i_wr_en     (w_beat && w_sel),
            .i_wr_set    (r_set),
            .i_wr_word   (r_beat),
            .i_wr_data   (memRdata),
            .i_fill_done (w_fill_done && w_sel),
            .i_fill_tag  (r_tag)
        );
    end

    if (WAYS > 1) begin : g_rr
        logic [VW-1:0] r_rr [SETS];
        always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
                for (int unsigned i = 0; i < SETS; i++) r_rr[i] <= '0;
            end else if (w_fill_done) begin
                r_rr[r_set] <= r_rr[r_set] + VW'(1);
            end
        end
        assign w_rr_sel = r_rr[w_set];
    end else begin : g_no_rr
        assign w_rr_sel = '0;
    end

    // Tags are unique within a set, so OR-ing the hit-masked words yields the hit data.
    always_comb begin
        w_any_hit  = |w_hit;
        w_hit_data = '0;
        w_victim   = w_rr_sel;
        w_found    = 1'b0;
        for (int unsigned i = 0; i < WAYS; i++) begin
            if (w_hit[i]) w_hit_data = w_hit_data | w_rdata[i];
            if (!w_valid[i] && !w_found) begin
                w_victim = VW'(i);
                w_found  = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next      = r_state;
        reqReady    = 1'b0;
        memReqValid = 1'b0;
        w_flush     = 1'b0;
        case (r_state)
            S_IDLE: begin
                reqReady = !flush;
                w_flush  = flush;
                if (reqValid && !flush && !w_any_hit) w_next = S_MISS_REQ;
            end
            S_MISS_REQ: begin
                memReqValid = 1'b1;
                if (memReqReady) w_next = S_REFILL;
            end
            S_REFILL: if (w_fill_done) w_next = S_RESP;
            S_RESP:   w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_tag        <= '0;
            r_set        <= '0;
            r_word       <= '0;
            r_beat       <= '0;
            r_victim     <= '0;
            r_fill_word  <= '0;
            r_rdata      <= '0;
            r_resp_valid <= 1'b0;
            r_is_hit     <= 1'b0;
            r_hit_cnt    <= '0;
            r_miss_cnt   <= '0;
        end else begin
            r_resp_valid <= 1'b0;
            if (w_accept) begin
                if (w_any_hit) begin
                    r_resp_valid <= 1'b1;
                    r_is_hit     <= 1'b1;
                    r_rdata      <= w_hit_data;
                    if (r_hit_cnt != '1) r_hit_cnt <= r_hit_cnt + 32'd1;
                end else begin
                    r_tag    <= w_tag;
                    r_set    <= w_set;
                    r_word   <= w_word;
                    r_victim <= w_victim;
                    r_beat   <= '0;
                    if (r_miss_cnt != '1) r_miss_cnt <= r_miss_cnt + 32'd1;
                end
            end
            // The requested word is captured in flight so RESP needs no array read.
            if (w_beat) begin
                r_beat <= r_beat + WORDS_LOG2'(1);
                if (r_beat == r_word) r_fill_word <= memRdata;
                if (w_last) begin
                    r_resp_valid <= 1'b1;
                    r_is_hit     <= 1'b0;
                    r_rdata      <= (r_beat == r_word) ? memRdata : r_fill_word;
                end
            end
        end
    end

    assign respValid = r_resp_valid;
    assign rdata     = r_rdata;
    assign is_hit    = r_is_hit;
    assign memAddr   = {r_tag, r_set, {WORDS_LOG2{1'b0}}};
    assign hitCount  = r_hit_cnt;
    assign missCount = r_miss_cnt;

endmodule

// File: tb/tb_icache_sa.sv
// Bench for icache_sa (WAYS=2, 16 sets, 4-word lines): vector table plus refill corner sequences.
// Responses are checked against a queue of expectations pushed when each request is driven.
module tb_icache_sa;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        reqValid = 1'b0;
    logic [31:2] addr = '0;
    logic        flush = 1'b0;
    logic        memReqReady = 1'b0;
    logic        memRespValid = 1'b0;
    logic [31:0] memRdata = '0;
    logic        reqReady, respValid, is_hit, memReqValid;
    logic [31:0] rdata, hitCount, missCount;
    logic [31:2] memAddr;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [31:0] data;
        logic        hit;
    } exp_t;
    exp_t sbq[$];

    typedef struct {
        bit          reset_before;
        logic [31:0] baddr;
        bit          exp_hit;
        int          delay;
        logic [31:0] exp_hits;
        logic [31:0] exp_miss;
    } vec_t;

    icache_sa #(.WAYS(2), .SETS_LOG2(4), .WORDS_LOG2(2)) dut (
        .clock        (clock),
        .reset        (reset),
        .reqValid     (reqValid),
        .addr         (addr),
        .reqReady     (reqReady),
        .flush        (flush),
        .respValid    (respValid),
        .rdata        (rdata),
        .is_hit       (is_hit),
        .memReqValid  (memReqValid),
        .memReqReady  (memReqReady),
        .memAddr      (memAddr),
        .memRespValid (memRespValid),
        .memRdata     (memRdata),
        .hitCount     (hitCount),
        .missCount    (missCount)
    );

    always #5 clock = ~clock;

    function automatic logic [29:0] wa(input logic [31:0] b);
        return b[31:2];
    endfunction

    function automatic logic [31:0] mem_word(input logic [29:0] w);
        if (w[29:2] == 28'h10) return 32'hA0 + {30'b0, w[1:0]};
        return 32'h1000_0000 | {2'b00, w};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        chk(name, {31'b0, act}, {31'b0, exp});
    endtask

    always @(negedge clock) begin
        exp_t e;
        if (!reset && respValid === 1'b1) begin
            if (sbq.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_resp: got rdata %h is_hit %b expected no response at %0t",
                         rdata, is_hit, $time);
            end else begin
                e = sbq.pop_front();
                chk("resp_rdata", rdata, e.data);
                chk1("resp_is_hit", is_hit, e.hit);
            end
        end
    end

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        reqValid = 1'b0;
        flush = 1'b0;
        memReqReady = 1'b0;
        memRespValid = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        #1;
        chk1("rst_reqReady", reqReady, 1'b1);
        chk1("rst_respValid", respValid, 1'b0);
        chk1("rst_memReqValid", memReqValid, 1'b0);
        chk1("rst_is_hit", is_hit, 1'b0);
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_memAddr", {2'b00, memAddr}, 32'h0);
        chk("rst_hitCount", hitCount, 32'h0);
        chk("rst_missCount", missCount, 32'h0);
    endtask

    // Memory side of one refill: request wait, backpressure, handshake, then nbeats beats.
    task automatic serve(input logic [29:0] line, input int delay, input int nbeats);
        for (int i = 0; i < 20 && memReqValid !== 1'b1; i++) @(negedge clock);
        chk1("memReqValid", memReqValid, 1'b1);
        if (memReqValid !== 1'b1) return;
        chk("memAddr", {2'b00, memAddr}, {2'b00, line});
        for (int i = 0; i < delay; i++) begin
            @(negedge clock);
            chk1("hold_memReqValid", memReqValid, 1'b1);
            chk("hold_memAddr", {2'b00, memAddr}, {2'b00, line});
        end
        memReqReady = 1'b1;
        @(negedge clock);
        memReqReady = 1'b0;
        chk1("memReqValid_after_hs", memReqValid, 1'b0);
        for (int k = 0; k < nbeats; k++) begin
            memRespValid = 1'b1;
            memRdata = mem_word(line | 30'(k));
            @(negedge clock);
        end
        memRespValid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && sbq.size() != 0; i++) @(negedge clock);
        if (sbq.size() != 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL resp_timeout: got %0d pending responses expected 0 at %0t", sbq.size(), $time);
            sbq.delete();
        end
    endtask

    task automatic fetch(input logic [31:0] baddr, input bit exp_hit, input int delay);
        exp_t e;
        logic [29:0] line;
        line = wa(baddr) & ~30'h3;
        @(negedge clock);
        reqValid = 1'b1;
        addr = wa(baddr);
        #1;
        chk1("reqReady", reqReady, 1'b1);
        e.data = mem_word(wa(baddr));
        e.hit = exp_hit;
        sbq.push_back(e);
        @(negedge clock);
        reqValid = 1'b0;
        if (!exp_hit) serve(line, delay, 4);
        drain();
    endtask

    vec_t tbl[14];

    initial begin : main
        exp_t e;
        // Set 0 holds tags 0,1,2 (0x000/0x100/0x200); with 2 ways the third fill evicts by round robin.
        tbl = '{
            '{1'b1, 32'h100, 1'b0, 2, 32'd0, 32'd1},
            '{1'b0, 32'h10C, 1'b1, 0, 32'd1, 32'd1},
            '{1'b0, 32'h104, 1'b1, 0, 32'd2, 32'd1},
            '{1'b1, 32'h000, 1'b0, 0, 32'd0, 32'd1},
            '{1'b0, 32'h100, 1'b0, 1, 32'd0, 32'd2},
            '{1'b0, 32'h200, 1'b0, 0, 32'd0, 32'd3},
            '{1'b0, 32'h104, 1'b1, 0, 32'd1, 32'd3},
            '{1'b0, 32'h000, 1'b0, 0, 32'd1, 32'd4},
            '{1'b0, 32'h208, 1'b1, 0, 32'd2, 32'd4},
            '{1'b0, 32'h100, 1'b0, 0, 32'd2, 32'd5},
            '{1'b0, 32'h00C, 1'b1, 0, 32'd3, 32'd5},
            '{1'b0, 32'h0F4, 1'b0, 0, 32'd3, 32'd6},
            '{1'b0, 32'h0F0, 1'b1, 0, 32'd4, 32'd6},
            '{1'b0, 32'h108, 1'b1, 0, 32'd5, 32'd6}
        };

        for (int i = 0; i < 14; i++) begin
            if (tbl[i].reset_before) do_reset();
            fetch(tbl[i].baddr, tbl[i].exp_hit, tbl[i].delay);
            chk("hitCount", hitCount, tbl[i].exp_hits);
            chk("missCount", missCount, tbl[i].exp_miss);
        end

        // Back-to-back hits, one per cycle.
        @(negedge clock);
        reqValid = 1'b1;
        addr = wa(32'h100);
        e.data = 32'hA0; e.hit = 1'b1;
        sbq.push_back(e);
        @(negedge clock);
        addr = wa(32'h10C);
        #1;
        chk1("b2b_reqReady", reqReady, 1'b1);
        e.data = 32'hA3; e.hit = 1'b1;
        sbq.push_back(e);
        @(negedge clock);
        reqValid = 1'b0;
        drain();
        chk("b2b_hitCount", hitCount, 32'd7);

        // Flush wins over a simultaneous request.
        @(negedge clock);
        flush = 1'b1;
        reqValid = 1'b1;
        addr = wa(32'h108);
        #1;
        chk1("flush_reqReady", reqReady, 1'b0);
        @(negedge clock);
        flush = 1'b0;
        reqValid = 1'b0;
        chk1("flush_no_resp", respValid, 1'b0);
        chk("flush_missCount", missCount, 32'd6);
        fetch(32'h108, 1'b0, 0);
        chk("post_flush_missCount", missCount, 32'd7);
        chk("post_flush_hitCount", hitCount, 32'd7);

        // Long backpressure, then reset after two of four beats.
        @(negedge clock);
        reqValid = 1'b1;
        addr = wa(32'h300);
        @(negedge clock);
        reqValid = 1'b0;
        serve(wa(32'h300), 10, 2);
        #2 reset = 1'b1;
        #1;
        chk1("midfill_rst_reqReady", reqReady, 1'b1);
        chk1("midfill_rst_memReqValid", memReqValid, 1'b0);
        @(negedge clock);
        reset = 1'b0;
        for (int i = 0; i < 2; i++) begin
            memRespValid = 1'b1;
            memRdata = 32'hDEAD_BEEF;
            @(negedge clock);
            chk1("stale_beat_memReqValid", memReqValid, 1'b0);
            chk1("stale_beat_respValid", respValid, 1'b0);
        end
        memRespValid = 1'b0;
        fetch(32'h300, 1'b0, 0);
        chk("after_rst_missCount", missCount, 32'd1);
        chk("after_rst_hitCount", hitCount, 32'd0);

        // Reset while the request is held off must drop memReqValid without a clock edge.
        @(negedge clock);
        reqValid = 1'b1;
        addr = wa(32'h700);
        @(negedge clock);
        reqValid = 1'b0;
        chk1("pre_rst_memReqValid", memReqValid, 1'b1);
        #2 reset = 1'b1;
        #1;
        chk1("async_rst_memReqValid", memReqValid, 1'b0);
        @(negedge clock);
        reset = 1'b0;
        fetch(32'h300, 1'b0, 0);

        // Saturation of the miss counter.
        @(negedge clock);
        force dut.r_miss_cnt = 32'hFFFF_FFFE;
        @(negedge clock);
        release dut.r_miss_cnt;
        fetch(32'h400, 1'b0, 0);
        chk("sat_missCount_1", missCount, 32'hFFFF_FFFF);
        fetch(32'h500, 1'b0, 0);
        chk("sat_missCount_2", missCount, 32'hFFFF_FFFF);

        repeat (3) @(negedge clock);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
